// File: rtl/mul_arb_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: FSM state encoding,
// default width constants and an index-width helper.
package mul_arb_pkg;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_W_IN    = 16;
    localparam int DEF_W_OUT   = 32;
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_t;

    // Bits needed to encode values 0..value-1; never returns less than 1 so
    // the result is always usable as a vector width.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/mul_share_arbiter_rr_arbiter.sv
// Round-robin search: starting just after the pointer and wrapping, pick the
// first asserted request. Purely combinational; the pointer register lives in
// the parent so it only advances when an operation is actually launched.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx
);

    // Walk offsets from farthest to nearest so the nearest hit after ptr wins.
    always_comb begin
        int cand;
        gnt  = '0;
        idx  = '0;
        cand = 0;
        for (int off = N_REQ; off >= 1; off--) begin
            cand = (int'(ptr) + off) % N_REQ;
            if (req[cand]) begin
                gnt       = '0;
                gnt[cand] = 1'b1;
                idx       = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one start/done multiplier among N_REQ requesters. The winner's
// operands are latched, dp_start is pulsed, and the product is handed back
// with a one-cycle resp_valid strobe on the winner's lane.
// Optional feature: define ARB_TIMEOUT_EN to abort a WAIT that lasts TIMEOUT
// cycles, answering with resp_err=1 and resp_data=0.
module mul_share_arbiter
    import mul_arb_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int W_IN    = DEF_W_IN,
    parameter int W_OUT   = DEF_W_OUT,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*W_IN-1:0]  x1_in,
    input  logic [N_REQ*W_IN-1:0]  x2_in,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       resp_valid,
    output logic [W_OUT-1:0]       resp_data,
    output logic                   resp_err,
    output logic                   busy,
    output logic                   dp_start,
    output logic [W_IN-1:0]        dp_x1,
    output logic [W_IN-1:0]        dp_x2,
    input  logic [W_OUT-1:0]       dp_out,
    input  logic                   dp_done
);

    localparam int IDX_W = clog2(N_REQ);

    // The product is passed through untouched, so the widths must line up.
    generate
        if (W_OUT != 2 * W_IN) begin : g_width_check
            $error("mul_share_arbiter: W_OUT must equal 2*W_IN");
        end
    endgenerate

    // Unpack per-requester operand slices.
    logic [W_IN-1:0] x1_slice [N_REQ];
    logic [W_IN-1:0] x2_slice [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign x1_slice[gi] = x1_in[gi*W_IN +: W_IN];
            assign x2_slice[gi] = x2_in[gi*W_IN +: W_IN];
        end
    endgenerate

    arb_state_t       state_reg, state_next;
    logic [IDX_W-1:0] ptr_reg,   ptr_next;
    logic [IDX_W-1:0] idx_reg,   idx_next;
    logic [N_REQ-1:0] sel_reg,   sel_next;
    logic [W_IN-1:0]  x1_reg,    x1_next;
    logic [W_IN-1:0]  x2_reg,    x2_next;
    logic [W_OUT-1:0] res_reg,   res_next;

    logic [N_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0] arb_idx;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             err_reg, err_next;
    logic             timed_out;
    assign timed_out = (cnt_reg == CNT_W'(TIMEOUT));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
`endif

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req (req),
        .ptr (ptr_reg),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    // Next-state and output decode for the IDLE/LAUNCH/WAIT/RESP sequencer.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        idx_next   = idx_reg;
        sel_next   = sel_reg;
        x1_next    = x1_reg;
        x2_next    = x2_reg;
        res_next   = res_reg;
`ifdef ARB_TIMEOUT_EN
        cnt_next   = cnt_reg;
        err_next   = err_reg;
`endif

        case (state_reg)
            ST_IDLE: begin
                if (|req) begin
                    idx_next   = arb_idx;
                    sel_next   = arb_gnt;
                    x1_next    = x1_slice[arb_idx];
                    x2_next    = x2_slice[arb_idx];
                    state_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                // Rotation advances only once an op is really issued.
                ptr_next   = idx_reg;
                state_next = ST_WAIT;
`ifdef ARB_TIMEOUT_EN
                cnt_next   = '0;
                err_next   = 1'b0;
`endif
            end
            ST_WAIT: begin
                if (dp_done) begin
                    res_next   = dp_out;
                    state_next = ST_RESP;
                end
`ifdef ARB_TIMEOUT_EN
                else if (timed_out) begin
                    res_next   = '0;
                    err_next   = 1'b1;
                    state_next = ST_RESP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
`endif
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        busy       = (state_reg != ST_IDLE);
        dp_start   = (state_reg == ST_LAUNCH);
        gnt        = (state_reg != ST_IDLE) ? sel_reg : '0;
        resp_valid = (state_reg == ST_RESP) ? sel_reg : '0;
        resp_data  = (state_reg == ST_RESP) ? res_reg : '0;
        dp_x1      = x1_reg;
        dp_x2      = x2_reg;
`ifdef ARB_TIMEOUT_EN
        resp_err   = (state_reg == ST_RESP) && err_reg;
`else
        resp_err   = 1'b0;
`endif
    end

    // State and datapath registers; reset drops any in-flight operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= IDX_W'(N_REQ - 1);
            idx_reg   <= '0;
            sel_reg   <= '0;
            x1_reg    <= '0;
            x2_reg    <= '0;
            res_reg   <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            idx_reg   <= idx_next;
            sel_reg   <= sel_next;
            x1_reg    <= x1_next;
            x2_reg    <= x2_next;
            res_reg   <= res_next;
`ifdef ARB_TIMEOUT_EN
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
`endif
        end
    end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Self-checking bench for mul_share_arbiter: vector table, hand-written
// corner sequences, and a randomized phase against a transaction-level model.
// Define ARB_TIMEOUT_EN to also exercise the timeout path.
module tb_mul_share_arbiter;

    localparam int N  = 4;
    localparam int WI = 16;
    localparam int WO = 32;
    localparam int TO = 64;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*WI-1:0] x1_in = '0;
    logic [N*WI-1:0] x2_in = '0;
    logic [N-1:0]   gnt, resp_valid;
    logic [WO-1:0]  resp_data;
    logic           resp_err, busy, dp_start;
    logic [WI-1:0]  dp_x1, dp_x2;
    logic [WO-1:0]  dp_out = '0;
    logic           dp_done = 1'b0;

    int n_err = 0;
    int n_checks = 0;
    int cyc = 0;
    int n_start = 0;
    int last_start = 0;
    int dp_cnt = 0;
    int dp_delay = 4;
    bit dp_rand = 0;
    bit dp_hang = 0;
    bit onehot_bad = 0;

    mul_share_arbiter #(.N_REQ(N), .W_IN(WI), .W_OUT(WO), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .x1_in(x1_in), .x2_in(x2_in),
        .gnt(gnt), .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_err(resp_err), .busy(busy), .dp_start(dp_start),
        .dp_x1(dp_x1), .dp_x2(dp_x2), .dp_out(dp_out), .dp_done(dp_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in multiplier: answers dp_start after a programmable delay.
    always @(negedge clk) begin
        dp_done = 1'b0;
        dp_out  = 32'hDEAD_BEEF;
        if (!rst) begin
            dp_cnt = 0;
        end else if (dp_start) begin
            n_start++;
            last_start = cyc;
            dp_cnt = dp_hang ? 0 : (dp_rand ? int'($urandom_range(1, 6)) : dp_delay);
        end else if (dp_cnt > 0) begin
            dp_cnt--;
            if (dp_cnt == 0) begin
                dp_done = 1'b1;
                dp_out  = {16'd0, dp_x1} * {16'd0, dp_x2};
            end
        end
        if ($countones(gnt) > 1 || $countones(resp_valid) > 1) onehot_bad = 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_resp(input string name, input int bound, output logic [N-1:0] v,
                             output logic [WO-1:0] d, output logic e, output int lat);
        bit ok;
        ok = 0; v = '0; d = '0; e = 1'b0; lat = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (resp_valid != '0) begin
                v = resp_valid; d = resp_data; e = resp_err;
                lat = cyc - last_start;
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_checks++; n_err++;
            $display("FAIL %s: no resp_valid within %0d cycles", name, bound);
        end
    endtask

    task automatic wait_start(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dp_start) begin ok = 1; break; end
        end
        if (!ok) begin
            n_checks++; n_err++;
            $display("FAIL %s: no dp_start within 20 cycles", name);
        end
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_busy"}, 64'(busy), 0);
        chk({name, "_gnt"}, 64'(gnt), 0);
        chk({name, "_start"}, 64'(dp_start), 0);
        chk({name, "_x1"}, 64'(dp_x1), 0);
        chk({name, "_x2"}, 64'(dp_x2), 0);
        chk({name, "_rv"}, 64'(resp_valid), 0);
        chk({name, "_rd"}, 64'(resp_data), 0);
        chk({name, "_err"}, 64'(resp_err), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; req = '0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        logic [N-1:0]    r;
        logic [N*WI-1:0] x1;
        logic [N*WI-1:0] x2;
        int              dly;
        logic [N-1:0]    eg;
        logic [WO-1:0]   ed;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic [N-1:0]  v;
        logic [WO-1:0] d;
        logic          e;
        int            lat, s0, pulses, last, c;
        logic [N-1:0]  rq;
        logic [WI-1:0] ra [N];
        logic [WI-1:0] rb [N];
        logic [N*WI-1:0] opa, opb;

        opa = {16'd13, 16'd12, 16'd11, 16'd10};
        opb = {16'd6, 16'd5, 16'd4, 16'd3};
        // Pointer starts at N-1, so the expected winners follow the rotation.
        tbl[0] = '{4'b0001, {48'd0, 16'd15}, {48'd0, 16'd10}, 4, 4'b0001, 32'd150};
        tbl[1] = '{4'b1111, opa, opb, 2, 4'b0010, 32'd44};
        tbl[2] = '{4'b1001, opa, opb, 3, 4'b1000, 32'd78};
        tbl[3] = '{4'b0110, opa, opb, 5, 4'b0010, 32'd44};
        tbl[4] = '{4'b0001, {48'd0, 16'hFFFF}, {48'd0, 16'hFFFF}, 1, 4'b0001, 32'hFFFE_0001};
        tbl[5] = '{4'b0101, opa, opb, 7, 4'b0100, 32'd60};
        tbl[6] = '{4'b0011, opa, opb, 3, 4'b0001, 32'd30};
        tbl[7] = '{4'b1000, {16'd0, 48'd0}, {16'd1234, 48'd0}, 2, 4'b1000, 32'd0};

        // Reset state
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b1;

        // Table-driven single operations
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            req = tbl[i].r; x1_in = tbl[i].x1; x2_in = tbl[i].x2; dp_delay = tbl[i].dly;
            s0 = n_start;
            wait_resp($sformatf("vec%0d", i), 100, v, d, e, lat);
            chk($sformatf("vec%0d_rv", i), 64'(v), 64'(tbl[i].eg));
            chk($sformatf("vec%0d_gnt", i), 64'(gnt), 64'(tbl[i].eg));
            chk($sformatf("vec%0d_data", i), 64'(d), 64'(tbl[i].ed));
            chk($sformatf("vec%0d_err", i), 64'(e), 0);
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(tbl[i].dly + 1));
            chk($sformatf("vec%0d_starts", i), 64'(n_start - s0), 1);
            req = '0;
            @(negedge clk);
            chk($sformatf("vec%0d_idle", i), 64'(busy), 0);
        end

        // Contention: all four held, expect strict rotation 0,1,2,3,0
        do_reset();
        for (int j = 0; j < N; j++) begin
            x1_in[j*WI +: WI] = WI'(j);
            x2_in[j*WI +: WI] = 16'd100;
        end
        dp_delay = 3;
        s0 = n_start;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_resp($sformatf("cont%0d", k), 100, v, d, e, lat);
            chk($sformatf("cont%0d_rv", k), 64'(v), 64'(1 << (k % N)));
            chk($sformatf("cont%0d_data", k), 64'(d), 64'((k % N) * 100));
        end
        req = '0;
        chk("cont_starts", 64'(n_start - s0), 5);
        @(negedge clk);

        // Late request: 2 is served first, then 0 which arrived during WAIT
        x1_in = '0; x2_in = '0;
        x1_in[2*WI +: WI] = 16'd5; x2_in[2*WI +: WI] = 16'd9;
        req = 4'b0100; dp_delay = 6;
        wait_start("late_start");
        repeat (2) @(negedge clk);
        req[0] = 1'b1; x1_in[WI-1:0] = 16'd8; x2_in[WI-1:0] = 16'd3;
        wait_resp("late_a", 100, v, d, e, lat);
        chk("late_a_rv", 64'(v), 64'(4'b0100));
        chk("late_a_data", 64'(d), 45);
        req[2] = 1'b0;
        wait_resp("late_b", 100, v, d, e, lat);
        chk("late_b_rv", 64'(v), 64'(4'b0001));
        chk("late_b_data", 64'(d), 24);
        req = '0;
        @(negedge clk);

        // Operand hold: changing x1_in during WAIT must not matter
        x1_in = '0; x2_in = '0;
        x1_in[WI-1:0] = 16'd7; x2_in[WI-1:0] = 16'd6;
        req = 4'b0001; dp_delay = 6;
        wait_start("hold_start");
        repeat (2) @(negedge clk);
        x1_in[WI-1:0] = 16'd99;
        @(negedge clk);
        chk("hold_dpx1", 64'(dp_x1), 7);
        wait_resp("hold", 100, v, d, e, lat);
        chk("hold_data", 64'(d), 42);
        req = '0;
        @(negedge clk);

        // Reset mid-WAIT: asynchronous clear, op dropped, pointer back to N-1
        x1_in = '0; x2_in = '0;
        x1_in[WI-1:0] = 16'd21; x2_in[WI-1:0] = 16'd2;
        x1_in[WI +: WI] = 16'd5; x2_in[WI +: WI] = 16'd5;
        req = 4'b0001; dp_delay = 10;
        wait_start("rstw_start");
        repeat (2) @(negedge clk);
        rst = 1'b0; req = '0;
        #1;
        chk_idle_outputs("rstw");
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (resp_valid != '0) pulses++;
        end
        chk("rstw_no_resp", 64'(pulses), 0);
        req = 4'b0011; dp_delay = 2;
        wait_resp("rstw_a", 100, v, d, e, lat);
        chk("rstw_a_rv", 64'(v), 64'(4'b0001));
        chk("rstw_a_data", 64'(d), 42);
        req[0] = 1'b0;
        wait_resp("rstw_b", 100, v, d, e, lat);
        chk("rstw_b_rv", 64'(v), 64'(4'b0010));
        chk("rstw_b_data", 64'(d), 25);
        req = '0;

        // Randomized phase against a transaction-level round-robin model
        do_reset();
        dp_rand = 1;
        last = N - 1;
        rq = '0;
        for (int j = 0; j < N; j++) begin
            ra[j] = WI'($urandom); rb[j] = WI'($urandom);
            if ($urandom_range(0, 1) == 1) rq[j] = 1'b1;
        end
        if (rq == '0) rq[$urandom_range(0, N - 1)] = 1'b1;
        for (int j = 0; j < N; j++) begin
            x1_in[j*WI +: WI] = ra[j]; x2_in[j*WI +: WI] = rb[j];
        end
        req = rq;
        for (int op = 0; op < 40; op++) begin
            c = 0;
            for (int off = 1; off <= N; off++) begin
                if (rq[(last + off) % N]) begin c = (last + off) % N; break; end
            end
            wait_resp($sformatf("rnd%0d", op), 100, v, d, e, lat);
            chk($sformatf("rnd%0d_rv", op), 64'(v), 64'(1 << c));
            chk($sformatf("rnd%0d_data", op), 64'(d), 64'(32'(ra[c]) * 32'(rb[c])));
            last = c;
            rq[c] = 1'b0;
            for (int j = 0; j < N; j++) begin
                if (!rq[j] && $urandom_range(0, 1) == 1) begin
                    rq[j] = 1'b1; ra[j] = WI'($urandom); rb[j] = WI'($urandom);
                end
            end
            if (rq == '0) begin
                c = int'($urandom_range(0, N - 1));
                rq[c] = 1'b1; ra[c] = WI'($urandom); rb[c] = WI'($urandom);
            end
            for (int j = 0; j < N; j++) begin
                x1_in[j*WI +: WI] = ra[j]; x2_in[j*WI +: WI] = rb[j];
            end
            req = rq;
        end
        req = '0;
        dp_rand = 0;
        repeat (12) @(negedge clk);
        chk("rnd_idle", 64'(busy), 0);

`ifdef ARB_TIMEOUT_EN
        // Timeout: datapath never answers
        dp_hang = 1;
        x1_in = '0; x2_in = '0;
        x1_in[WI-1:0] = 16'd3; x2_in[WI-1:0] = 16'd3;
        req = 4'b0001;
        wait_resp("tmo", TO + 20, v, d, e, lat);
        chk("tmo_rv", 64'(v), 64'(4'b0001));
        chk("tmo_err", 64'(e), 1);
        chk("tmo_data", 64'(d), 0);
        chk("tmo_lat", 64'(lat), 64'(TO + 2));
        req = '0;
        dp_hang = 0;
        @(negedge clk);
`endif

        chk("onehot", 64'(onehot_bad), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
